// File: rtl/sys_defs.sv
// Shared types for the load buffer: issue-FSM state encoding, the per-load
// entry record, and the doubleword-to-word select helper.
package sys_defs;

    // System-wide ROB tag width; the load_buffer ROB_TAG_W parameter must not exceed it.
    localparam int unsigned LbRobTagW = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWait  = 2'd1,
        StDrain = 2'd2
    } lb_state_t;

    typedef struct packed {
        logic [31:0]          addr;
        logic [LbRobTagW-1:0] rob_tag;
        logic [4:0]           dest;
    } lb_entry_t;

    // Memory returns an aligned doubleword; address bit 2 picks the upper word.
    function automatic logic [31:0] lb_word_sel(input logic sel_hi, input logic [63:0] data);
        return sel_hi ? data[63:32] : data[31:0];
    endfunction

endpackage

// File: rtl/load_buffer.sv
// Load buffer: in-order circular queue of load addresses captured from the
// address unit, a three-state issue FSM allowing one outstanding memory read,
// and a single writeback register held until the CDB accepts it.
module load_buffer
    import sys_defs::*;
#(
    parameter int unsigned LB_SIZE   = 4,
    parameter int unsigned ROB_TAG_W = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 alloc_valid,
    input  logic [31:0]          alloc_addr,
    input  logic [ROB_TAG_W-1:0] alloc_rob_tag,
    input  logic [4:0]           alloc_dest,
    input  logic                 exec_stall,
    input  logic                 mem_resp,
    input  logic [63:0]          mem_data,
    input  logic                 wr_written,
    output logic                 lb_full,
    output logic                 lb_read_mem,
    output logic [31:0]          mem_addr,
    output logic                 wr_valid,
    output logic [31:0]          wr_data,
    output logic [ROB_TAG_W-1:0] wr_rob_tag,
    output logic [4:0]           wr_dest
);

    localparam int unsigned PtrW = (LB_SIZE > 1) ? $clog2(LB_SIZE) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(LB_SIZE);

    // Queue storage and bookkeeping
    lb_entry_t        r_entries [LB_SIZE];
    logic [PtrW-1:0]  r_head;
    logic [PtrW-1:0]  r_tail;
    logic [CntW-1:0]  r_count;

    // Issue FSM
    lb_state_t        r_state;
    lb_state_t        w_state_next;

    // Writeback register
    logic                 r_wr_valid;
    logic [31:0]          r_wr_data;
    logic [ROB_TAG_W-1:0] r_wr_rob_tag;
    logic [4:0]           r_wr_dest;

    // Decoded per-cycle events
    lb_entry_t w_head_entry;
    logic      w_empty;
    logic      w_issue;
    logic      w_alloc;
    logic      w_pop;
    logic      w_in_flight;

    assign w_head_entry = r_entries[r_head];
    assign w_empty      = (r_count == '0);
    assign lb_full      = (r_count == FullCnt);

    // A full buffer refuses allocation even when the head retires this cycle.
    assign w_alloc = alloc_valid & ~lb_full & ~flush;

    // Head retires only when its response lands in WAIT and no flush squashes it.
    assign w_pop = (r_state == StWait) & mem_resp & ~flush;

    // A read is (or is about to be) in flight, so a flush must drain its response.
    assign w_in_flight = (r_state == StWait) | (r_state == StDrain) | w_issue;

    assign wr_valid   = r_wr_valid;
    assign wr_data    = r_wr_data;
    assign wr_rob_tag = r_wr_rob_tag;
    assign wr_dest    = r_wr_dest;

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic; flush overrides normal transitions
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_issue) begin
                    w_state_next = StWait;
                end
            end
            StWait: begin
                if (mem_resp) begin
                    w_state_next = StIdle;
                end
            end
            StDrain: begin
                if (mem_resp) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
        if (flush) begin
            // A same-cycle response retires the outstanding read, so nothing is left to drain.
            w_state_next = (w_in_flight && !mem_resp) ? StDrain : StIdle;
        end
    end

    // FSM outputs: single-cycle read request for the head entry from IDLE
    always_comb begin
        w_issue     = (r_state == StIdle) && !w_empty && !exec_stall;
        lb_read_mem = w_issue;
        mem_addr    = w_head_entry.addr;
    end

    // Circular queue: allocate at tail, retire at head, flush empties everything
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < LB_SIZE; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            if (w_alloc) begin
                r_entries[r_tail] <= '{
                    addr:    alloc_addr,
                    rob_tag: LbRobTagW'(alloc_rob_tag),
                    dest:    alloc_dest
                };
                r_tail <= r_tail + PtrW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PtrW'(1);
            end
            unique case ({w_alloc, w_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Writeback register: load on retire, hold until the CDB accepts it
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_valid   <= 1'b0;
            r_wr_data    <= '0;
            r_wr_rob_tag <= '0;
            r_wr_dest    <= '0;
        end else if (flush) begin
            r_wr_valid <= 1'b0;
        end else if (w_pop) begin
            r_wr_valid   <= 1'b1;
            r_wr_data    <= lb_word_sel(w_head_entry.addr[2], mem_data);
            r_wr_rob_tag <= ROB_TAG_W'(w_head_entry.rob_tag);
            r_wr_dest    <= w_head_entry.dest;
        end else if (wr_written) begin
            r_wr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_load_buffer.sv
// Self-checking bench for load_buffer: directed scenarios followed by random
// traffic, all compared every cycle against a queue-based reference model.
module tb_load_buffer;

    localparam int unsigned LB_SIZE   = 4;
    localparam int unsigned ROB_TAG_W = 4;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 flush;
    logic                 alloc_valid;
    logic [31:0]          alloc_addr;
    logic [ROB_TAG_W-1:0] alloc_rob_tag;
    logic [4:0]           alloc_dest;
    logic                 exec_stall;
    logic                 mem_resp;
    logic [63:0]          mem_data;
    logic                 wr_written;
    logic                 lb_full;
    logic                 lb_read_mem;
    logic [31:0]          mem_addr;
    logic                 wr_valid;
    logic [31:0]          wr_data;
    logic [ROB_TAG_W-1:0] wr_rob_tag;
    logic [4:0]           wr_dest;

    always #5 clock = ~clock;

    load_buffer #(
        .LB_SIZE   (LB_SIZE),
        .ROB_TAG_W (ROB_TAG_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .flush         (flush),
        .alloc_valid   (alloc_valid),
        .alloc_addr    (alloc_addr),
        .alloc_rob_tag (alloc_rob_tag),
        .alloc_dest    (alloc_dest),
        .exec_stall    (exec_stall),
        .mem_resp      (mem_resp),
        .mem_data      (mem_data),
        .wr_written    (wr_written),
        .lb_full       (lb_full),
        .lb_read_mem   (lb_read_mem),
        .mem_addr      (mem_addr),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .wr_rob_tag    (wr_rob_tag),
        .wr_dest       (wr_dest)
    );

    // Reference model: pending loads in program order, plus read/drain flags
    typedef struct {
        logic [31:0]          addr;
        logic [ROB_TAG_W-1:0] tag;
        logic [4:0]           dest;
    } ld_t;

    ld_t                  m_q[$];
    bit                   m_pend;
    bit                   m_drain;
    bit                   m_wr_valid;
    logic [31:0]          m_wr_data;
    logic [ROB_TAG_W-1:0] m_wr_tag;
    logic [4:0]           m_wr_dest;
    bit                   last_read;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance model and clock.
    task automatic step(input bit rst, input bit fl, input bit av, input logic [31:0] aa,
                        input logic [ROB_TAG_W-1:0] at, input logic [4:0] ad, input bit es,
                        input bit mr, input logic [63:0] md, input bit ww);
        bit exp_full;
        bit exp_read;
        ld_t e;
        reset = rst; flush = fl; alloc_valid = av; alloc_addr = aa; alloc_rob_tag = at;
        alloc_dest = ad; exec_stall = es; mem_resp = mr; mem_data = md; wr_written = ww;
        #1;
        exp_full = (m_q.size() == LB_SIZE);
        exp_read = !m_pend && !m_drain && (m_q.size() > 0) && !es;
        check_eq("lb_full", lb_full, exp_full);
        check_eq("lb_read_mem", lb_read_mem, exp_read);
        if (exp_read) check_eq("mem_addr", mem_addr, m_q[0].addr);
        check_eq("wr_valid", wr_valid, m_wr_valid);
        if (m_wr_valid) begin
            check_eq("wr_data", wr_data, m_wr_data);
            check_eq("wr_rob_tag", wr_rob_tag, m_wr_tag);
            check_eq("wr_dest", wr_dest, m_wr_dest);
        end
        last_read = exp_read;
        if (rst) begin
            m_q.delete();
            m_pend = 0; m_drain = 0;
            m_wr_valid = 0; m_wr_data = '0; m_wr_tag = '0; m_wr_dest = '0;
        end else if (fl) begin
            m_drain = (m_pend || exp_read || m_drain) && !mr;
            m_pend = 0;
            m_q.delete();
            m_wr_valid = 0;
        end else begin
            if (m_pend && mr) begin
                e = m_q.pop_front();
                m_wr_valid = 1;
                m_wr_data  = e.addr[2] ? md[63:32] : md[31:0];
                m_wr_tag   = e.tag;
                m_wr_dest  = e.dest;
                m_pend     = 0;
            end else if (ww) begin
                m_wr_valid = 0;
            end
            if (m_drain && mr) m_drain = 0;
            if (exp_read) m_pend = 1;
            if (av && !exp_full) begin
                e.addr = aa; e.tag = at; e.dest = ad;
                m_q.push_back(e);
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic nop(input bit es, input bit ww);
        step(0, 0, 0, '0, '0, '0, es, 0, '0, ww);
    endtask

    task automatic alloc(input logic [31:0] aa, input logic [ROB_TAG_W-1:0] at,
                         input logic [4:0] ad, input bit es);
        step(0, 0, 1, aa, at, ad, es, 0, '0, 0);
    endtask

    task automatic resp(input logic [63:0] md, input bit ww);
        step(0, 0, 0, '0, '0, '0, 0, 1, md, ww);
    endtask

    // Issue and answer n loads from the head.
    task automatic serve(input int n);
        for (int k = 0; k < n; k++) begin
            nop(0, 1);
            resp({$urandom, $urandom}, 1);
        end
    endtask

    int resp_in;

    initial begin
        @(negedge clock);
        // Reset state
        step(1, 0, 0, '0, '0, '0, 0, 0, '0, 0);
        step(1, 0, 0, '0, '0, '0, 0, 0, '0, 0);
        check_eq("rst_full", lb_full, 1'b0);
        check_eq("rst_read", lb_read_mem, 1'b0);
        check_eq("rst_wr_valid", wr_valid, 1'b0);
        check_eq("rst_wr_data", wr_data, 32'h0);
        check_eq("rst_wr_tag", wr_rob_tag, 4'h0);
        check_eq("rst_wr_dest", wr_dest, 5'h0);

        // Single load, response next cycle, low word
        alloc(32'h100, 4'd3, 5'd5, 0);
        check_eq("t1_read", lb_read_mem, 1'b1);
        check_eq("t1_addr", mem_addr, 32'h100);
        nop(0, 0);
        resp(64'hAAAA_BBBB_1111_2222, 0);
        check_eq("t1_wr_valid", wr_valid, 1'b1);
        check_eq("t1_wr_data", wr_data, 32'h1111_2222);
        check_eq("t1_wr_tag", wr_rob_tag, 4'd3);
        check_eq("t1_wr_dest", wr_dest, 5'd5);
        nop(0, 1);
        check_eq("t1_wr_clear", wr_valid, 1'b0);

        // Fill to full, fifth ignored, in-order issue, 0x104 returns the high word
        alloc(32'h104, 4'd1, 5'd1, 1);
        alloc(32'h108, 4'd2, 5'd2, 1);
        alloc(32'h10C, 4'd3, 5'd3, 1);
        alloc(32'h110, 4'd4, 5'd4, 1);
        check_eq("t2_full", lb_full, 1'b1);
        alloc(32'h114, 4'd5, 5'd5, 1);
        check_eq("t2_still_full", lb_full, 1'b1);
        nop(0, 1);
        resp(64'h1234_5678_9ABC_DEF0, 0);
        check_eq("t2_high_word", wr_data, 32'h1234_5678);
        check_eq("t2_not_full", lb_full, 1'b0);
        serve(3);
        nop(0, 1);

        // Full buffer refuses allocation even while the head retires
        for (int k = 0; k < 4; k++) alloc(32'h200 + 32'(k * 4), 4'(k), 5'(k), 1);
        nop(0, 1);
        step(0, 0, 1, 32'h300, 4'hF, 5'h1F, 0, 1, 64'h5555_6666_7777_8888, 1);
        check_eq("t3_pop_full_alloc", lb_full, 1'b0);
        serve(3);
        nop(0, 1);

        // Stalled issue with writeback held, then released by wr_written
        alloc(32'h400, 4'd6, 5'd7, 0);
        nop(0, 0);
        resp(64'h0, 0);
        alloc(32'h404, 4'd7, 5'd8, 1);
        for (int k = 0; k < 3; k++) begin
            nop(1, 0);
            check_eq("t4_stall_read", lb_read_mem, 1'b0);
            check_eq("t4_wr_hold", wr_valid, 1'b1);
        end
        nop(1, 1);
        check_eq("t4_wr_cleared", wr_valid, 1'b0);
        serve(1);
        nop(0, 1);

        // Flush one cycle after issue, response two cycles later is discarded
        alloc(32'h500, 4'd2, 5'd9, 0);
        nop(0, 0);
        step(0, 1, 0, '0, '0, '0, 0, 0, '0, 0);
        nop(0, 0);
        resp(64'hFFFF_FFFF_FFFF_FFFF, 0);
        check_eq("t5_wr_valid", wr_valid, 1'b0);
        alloc(32'h508, 4'd3, 5'd10, 0);
        check_eq("t5_reissue", lb_read_mem, 1'b1);
        nop(0, 1);
        resp(64'hCAFE_0000_BEEF_0001, 0);
        check_eq("t5_wr_data", wr_data, 32'hBEEF_0001);
        nop(0, 1);

        // Alloc + pop in the same cycle with two resident loads; tail wraps over six loads
        alloc(32'h600, 4'd0, 5'd0, 1);
        alloc(32'h604, 4'd1, 5'd1, 1);
        for (int k = 2; k < 6; k++) begin
            nop(0, 1);
            step(0, 0, 1, 32'h600 + 32'(k * 4), 4'(k), 5'(k), 0, 1, {$urandom, $urandom}, 1);
        end
        serve(2);
        nop(0, 1);

        // Reset mid-transaction; late response is ignored
        alloc(32'h700, 4'd9, 5'd11, 0);
        nop(0, 0);
        step(1, 0, 0, '0, '0, '0, 0, 0, '0, 0);
        resp(64'h1111_1111_1111_1111, 0);
        check_eq("t7_wr_valid", wr_valid, 1'b0);
        check_eq("t7_read", lb_read_mem, 1'b0);

        // Random traffic with a memory that answers 1-3 cycles after each request
        resp_in = -1;
        for (int c = 0; c < 3000; c++) begin
            bit mr;
            mr = (resp_in == 0);
            if (resp_in >= 0) resp_in--;
            step(0, ($urandom_range(99) < 3), ($urandom_range(99) < 55),
                 $urandom & 32'hFFFF_FFFC, 4'($urandom), 5'($urandom),
                 ($urandom_range(99) < 25), mr, {$urandom, $urandom},
                 ($urandom_range(99) < 50));
            if (last_read) resp_in = int'($urandom_range(2, 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
